// File: rtl/rvfi_formal_pkg.sv
// Shared types and helpers for the formal fetch-bus models.
// Holds the queued fetch entry layout and the tracked-halfword selector.
package rvfi_formal_pkg;

    localparam int XLEN_MAX       = 64;
    localparam int HALFWORD_BYTES = 2;
    localparam int DELAY_W        = 4;

    typedef struct packed {
        logic [XLEN_MAX-1:0] addr;
        logic [31:0]         rdata;
        logic                fault;
        logic [DELAY_W-1:0]  delay;
    } fetch_entry_t;

    function automatic logic [15:0] hw_select(
        input logic [XLEN_MAX-1:0] addr,
        input logic [XLEN_MAX-1:0] tracked_addr,
        input logic [15:0]         tracked_data,
        input logic [15:0]         fill
    );
        return (addr == tracked_addr) ? tracked_data : fill;
    endfunction

endpackage

// File: rtl/rvfi_fetch_fifo.sv
// In-order circular queue of fetch entries.
// Every occupied slot counts its delay down toward zero each cycle.
module rvfi_fetch_fifo
    import rvfi_formal_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DEPTH-1:0] slot_valid;

    // Mark slots lying between the read pointer and read pointer + count.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset        = PW'(i) - rd_ptr;
            slot_valid[i] = ({1'b0, offset} < count);
        end
    end

    assign head = mem[rd_ptr];

    // Queue storage, pointers, occupancy and per-slot delay countdown.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (mem[i].delay != '0)) begin
                    mem[i].delay <= mem[i].delay - 1'b1;
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!resetn)
        !(push && (count == CW'(DEPTH)))
    );

endmodule

// File: rtl/rvfi_imem_fetch_model.sv
// Fetch-bus responder for formal imem checks.
// One tracked halfword is answered from imem_data, the rest from fill_data.
module rvfi_imem_fetch_model
    import rvfi_formal_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [31:0]     fill_data,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_addr,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]       count;
    fetch_entry_t        head;
    fetch_entry_t        push_entry;
    logic                accept;
    logic                pop;
    logic [XLEN_MAX-1:0] req_ext;
    logic [XLEN_MAX-1:0] nxt_ext;
    logic [XLEN_MAX-1:0] trk_ext;
    logic                unused_head;

    assign req_ready = resetn && (count < CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = resetn && (count != '0) && (head.delay == '0);
    assign pop       = rsp_valid && rsp_ready;

    // Build the entry captured at accept; the +2 address wraps at XLEN.
    always_comb begin
        req_ext = '0;
        nxt_ext = '0;
        trk_ext = '0;
        req_ext[XLEN-1:0] = req_addr;
        nxt_ext[XLEN-1:0] = req_addr + XLEN'(HALFWORD_BYTES);
        trk_ext[XLEN-1:0] = imem_addr;
        push_entry       = '0;
        push_entry.addr  = req_ext;
        push_entry.delay = DELAY_W'(LATENCY - 1);
        if (req_addr[0]) begin
            push_entry.fault = 1'b1;
        end else begin
            push_entry.rdata = {
                hw_select(nxt_ext, trk_ext, imem_data, fill_data[31:16]),
                hw_select(req_ext, trk_ext, imem_data, fill_data[15:0])
            };
        end
    end

    rvfi_fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    // Present the head entry only while it is valid; zeros otherwise.
    always_comb begin
        rsp_addr  = '0;
        rsp_rdata = '0;
        rsp_fault = 1'b0;
        if (rsp_valid) begin
            rsp_addr  = head.addr[XLEN-1:0];
            rsp_rdata = head.rdata;
            rsp_fault = head.fault;
        end
    end

    assign unused_head = ^head.addr;

    a_count_bound: assert property (
        @(posedge clk) disable iff (!resetn)
        count <= CW'(DEPTH)
    );

    a_rsp_stable: assert property (
        @(posedge clk) disable iff (!resetn)
        (rsp_valid && !rsp_ready) |=>
        (rsp_valid && $stable(rsp_addr) &&
         $stable(rsp_rdata) && $stable(rsp_fault))
    );

endmodule

// File: tb/tb_rvfi_imem_fetch_model.sv
// Directed bench for the imem fetch responder.
// Covers tracked halves, wrap, backpressure, fault, reset and LATENCY=1.
module tb_rvfi_imem_fetch_model;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;

    logic [31:0] a_fill, a_req_addr, a_rsp_addr, a_rsp_rdata;
    logic        a_req_valid, a_req_ready, a_rsp_valid;
    logic        a_rsp_ready, a_rsp_fault;

    logic [31:0] b_fill, b_req_addr, b_rsp_addr, b_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid;
    logic        b_rsp_ready, b_rsp_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvfi_imem_fetch_model #(.XLEN(32), .LATENCY(2), .DEPTH(4)) dut_a (
        .clk       (clk),
        .resetn    (resetn),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .fill_data (a_fill),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_addr  (a_req_addr),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_addr  (a_rsp_addr),
        .rsp_rdata (a_rsp_rdata),
        .rsp_fault (a_rsp_fault)
    );

    rvfi_imem_fetch_model #(.XLEN(32), .LATENCY(1), .DEPTH(4)) dut_b (
        .clk       (clk),
        .resetn    (resetn),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .fill_data (b_fill),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_addr  (b_req_addr),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_addr  (b_rsp_addr),
        .rsp_rdata (b_rsp_rdata),
        .rsp_fault (b_rsp_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v,
                         input logic [31:0] ad, input logic [31:0] d,
                         input logic f);
        chk({tag, "_valid"}, 64'(a_rsp_valid), 64'(v));
        chk({tag, "_addr"},  64'(a_rsp_addr),  64'(ad));
        chk({tag, "_rdata"}, 64'(a_rsp_rdata), 64'(d));
        chk({tag, "_fault"}, 64'(a_rsp_fault), 64'(f));
    endtask

    initial begin
        resetn      = 1'b0;
        imem_addr   = '0;
        imem_data   = '0;
        a_fill      = '0;
        a_req_addr  = '0;
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b0;
        b_fill      = '0;
        b_req_addr  = '0;
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;

        step();
        step();
        settle();
        chk("rst_req_ready", 64'(a_req_ready), 64'd0);
        chk_a("rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_b_valid", 64'(b_rsp_valid), 64'd0);

        resetn = 1'b1;
        settle();
        chk("post_rst_ready", 64'(a_req_ready), 64'd1);

        // 1: tracked low halfword
        imem_addr   = 32'h100;
        imem_data   = 16'hBEEF;
        a_fill      = 32'h12345678;
        a_req_addr  = 32'h100;
        a_req_valid = 1'b1;
        a_rsp_ready = 1'b1;
        settle();
        chk("t1_ready", 64'(a_req_ready), 64'd1);
        step();
        a_req_valid = 1'b0;
        a_fill      = 32'hDEADDEAD;
        settle();
        chk("t1_t1_valid", 64'(a_rsp_valid), 64'd0);
        step();
        chk_a("t1_rsp", 1'b1, 32'h100, 32'h1234BEEF, 1'b0);
        step();
        chk("t1_after_pop", 64'(a_rsp_valid), 64'd0);

        // 2: tracked high halfword via address wrap
        imem_addr   = 32'h0;
        imem_data   = 16'hA5A5;
        a_fill      = 32'hCAFEF00D;
        a_req_addr  = 32'hFFFFFFFE;
        a_req_valid = 1'b1;
        step();
        a_req_valid = 1'b0;
        settle();
        chk("t2_t1_valid", 64'(a_rsp_valid), 64'd0);
        step();
        chk_a("t2_rsp", 1'b1, 32'hFFFFFFFE, 32'hA5A5F00D, 1'b0);
        step();

        // 3: backpressure, fill to DEPTH, in-order drain
        imem_addr   = 32'h1000;
        a_rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_req_addr  = 32'h200 + 32'(4 * k);
            a_fill      = 32'h11110000 + 32'(k);
            a_req_valid = 1'b1;
            settle();
            chk($sformatf("t3_ready_%0d", k), 64'(a_req_ready),
                64'(k < 4));
            step();
        end
        a_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk_a($sformatf("t3_hold_%0d", k), 1'b1, 32'h200,
                  32'h11110000, 1'b0);
            chk($sformatf("t3_full_%0d", k), 64'(a_req_ready), 64'd0);
            step();
        end
        a_rsp_ready = 1'b1;
        settle();
        chk("t3_no_bypass", 64'(a_req_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk_a($sformatf("t3_drain_%0d", k), 1'b1,
                  32'h200 + 32'(4 * k), 32'h11110000 + 32'(k), 1'b0);
            step();
            if (k == 0) begin
                chk("t3_ready_back", 64'(a_req_ready), 64'd1);
            end
        end
        chk("t3_empty", 64'(a_rsp_valid), 64'd0);

        // 4: misaligned then aligned
        imem_addr   = 32'h100;
        imem_data   = 16'hBEEF;
        a_req_addr  = 32'h103;
        a_fill      = 32'h77778888;
        a_req_valid = 1'b1;
        step();
        a_req_addr  = 32'h100;
        a_fill      = 32'h55556666;
        step();
        a_req_valid = 1'b0;
        settle();
        chk_a("t4_fault", 1'b1, 32'h103, 32'h0, 1'b1);
        step();
        chk_a("t4_next", 1'b1, 32'h100, 32'h5555BEEF, 1'b0);
        step();
        chk("t4_empty", 64'(a_rsp_valid), 64'd0);

        // 5: reset with three requests in flight
        imem_addr   = 32'h1000;
        a_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_req_addr  = 32'h300 + 32'(4 * k);
            a_fill      = 32'h33330000 + 32'(k);
            a_req_valid = 1'b1;
            step();
        end
        a_req_valid = 1'b0;
        settle();
        chk("t5_pre_valid", 64'(a_rsp_valid), 64'd1);
        resetn = 1'b0;
        settle();
        chk_a("t5_in_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t5_in_rst_ready", 64'(a_req_ready), 64'd0);
        step();
        resetn      = 1'b1;
        a_rsp_ready = 1'b1;
        settle();
        chk("t5_ready", 64'(a_req_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5_stale_%0d", k), 64'(a_rsp_valid), 64'd0);
            step();
        end
        a_req_addr  = 32'h400;
        a_fill      = 32'h9999AAAA;
        a_req_valid = 1'b1;
        step();
        a_req_valid = 1'b0;
        settle();
        chk("t5_fresh_t1", 64'(a_rsp_valid), 64'd0);
        step();
        chk_a("t5_fresh", 1'b1, 32'h400, 32'h9999AAAA, 1'b0);
        step();

        // 6: LATENCY=1 streaming on dut_b
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b_req_addr  = 32'h500 + 32'(4 * k);
            b_fill      = 32'hF0000000 + 32'(k);
            b_req_valid = 1'b1;
            settle();
            chk($sformatf("t6_valid_%0d", k), 64'(b_rsp_valid),
                64'(k > 0));
            chk($sformatf("t6_ready_%0d", k), 64'(b_req_ready), 64'd1);
            if (k > 0) begin
                chk($sformatf("t6_addr_%0d", k), 64'(b_rsp_addr),
                    64'(32'h500 + 32'(4 * (k - 1))));
                chk($sformatf("t6_data_%0d", k), 64'(b_rsp_rdata),
                    64'(32'hF0000000 + 32'(k - 1)));
                chk($sformatf("t6_fault_%0d", k), 64'(b_rsp_fault),
                    64'd0);
            end
            step();
        end
        b_req_valid = 1'b0;
        settle();
        chk("t6_last_valid", 64'(b_rsp_valid), 64'd1);
        chk("t6_last_addr", 64'(b_rsp_addr), 64'h514);
        step();
        chk("t6_drained", 64'(b_rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
